store_buffer: RTL and testbench

Write-side counterpart of the writeback load-extension path: accepts SB/SH/SW stores from the MEM stage, replicates store data into byte lanes, generates byte enables, and queues the result in a small FIFO. The FIFO drains to data memory over a write/resp handshake. Sits between the EX/MEM latch and the data-memory write port. Also flags loads that hit a pending store, so hazard logic can stall.

---
 rtl/store_buffer_pkg.sv | 24 ++
 rtl/store_buffer_align.sv | 47 ++++
 rtl/store_buffer.sv | 168 ++++++++++++++++
 tb/tb_store_buffer.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: store encodings, queued entry layout
// and drain-FSM states.
package store_buffer_pkg;

   typedef logic [31:0] rv32i_word;

   typedef enum logic [2:0] {
      SB = 3'b000,
      SH = 3'b001,
      SW = 3'b010
   } store_funct3_t;

   typedef struct packed {
      rv32i_word  addr;
      rv32i_word  data;
      logic [3:0] mask;
   } sbuf_entry_t;

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } sbuf_state_t;

endpackage

// File: rtl/store_buffer_align.sv
// Combinational store aligner: replicates store data across byte lanes,
// builds the byte-enable mask and flags misaligned or reserved stores.
// Kept free of state so a future cache write path can reuse it.
module store_align
   import store_buffer_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] data,
   output logic [31:0] wdata,
   output logic [3:0]  mask,
   output logic        fault
);

   // Decode store width and lane placement; faulting stores produce no lanes.
   always_comb begin
      wdata = 32'h0000_0000;
      mask  = 4'b0000;
      fault = 1'b0;
      case (funct3)
         SB: begin
            wdata = {4{data[7:0]}};
            mask  = 4'b0001 << addr_lo;
         end
         SH: begin
            if (addr_lo[0]) begin
               fault = 1'b1;
            end else begin
               wdata = {2{data[15:0]}};
               mask  = 4'b0011 << {addr_lo[1], 1'b0};
            end
         end
         SW: begin
            if (addr_lo != 2'b00) begin
               fault = 1'b1;
            end else begin
               wdata = data;
               mask  = 4'b1111;
            end
         end
         default: begin
            fault = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the EX/MEM latch and the data-memory write port.
// Aligned stores are queued in a small FIFO and drained one at a time over a
// write/resp handshake; loads that hit a queued word raise ld_hazard.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        st_valid,
   input  logic [2:0]  st_funct3,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   output logic        st_ready,
   output logic        store_fault,
   input  logic        ld_valid,
   input  logic [31:0] ld_addr,
   output logic        ld_hazard,
   output logic        mem_write,
   output logic [31:0] mem_address,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_byte_enable,
   input  logic        mem_resp,
   output logic        empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   sbuf_entry_t      entries_r [DEPTH];
   logic [DEPTH-1:0] valid_r;
   logic [PTR_W-1:0] head_r;
   logic [PTR_W-1:0] tail_r;
   logic [CNT_W-1:0] count_r;
   sbuf_state_t      state_r;
   logic             mem_write_r;
   logic             store_fault_r;

   logic [31:0]      align_wdata_s;
   logic [3:0]       align_mask_s;
   logic             align_fault_s;
   logic             full_s;
   logic             accept_s;
   logic             push_s;
   logic             pop_s;
   logic             hit_s;
   logic             unused_s;

   store_align u_align (
      .funct3  (st_funct3),
      .addr_lo (st_addr[1:0]),
      .data    (st_data),
      .wdata   (align_wdata_s),
      .mask    (align_mask_s),
      .fault   (align_fault_s)
   );

   // Full is taken from registered count only, so a same-cycle pop never frees a slot.
   assign full_s   = (count_r == CNT_W'(DEPTH));
   assign accept_s = st_valid && !full_s;
   assign push_s   = accept_s && !align_fault_s;
   assign pop_s    = (state_r == WRITE) && mem_resp;

   assign st_ready    = !full_s;
   assign empty       = (count_r == CNT_W'(0));
   assign mem_write   = mem_write_r;
   assign store_fault = store_fault_r;
   assign unused_s    = &{1'b0, ld_addr[1:0]};

   // FIFO storage, pointers and occupancy count.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         head_r  <= PTR_W'(0);
         tail_r  <= PTR_W'(0);
         count_r <= CNT_W'(0);
         valid_r <= DEPTH'(0);
         for (int i = 0; i < DEPTH; i++) begin
            entries_r[i] <= '0;
         end
      end else begin
         if (pop_s) begin
            valid_r[head_r] <= 1'b0;
            head_r          <= head_r + PTR_W'(1);
         end
         if (push_s) begin
            entries_r[tail_r] <= '{addr: {st_addr[31:2], 2'b00},
                                   data: align_wdata_s,
                                   mask: align_mask_s};
            valid_r[tail_r]   <= 1'b1;
            tail_r            <= tail_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Drain FSM: one write per entry, with an idle cycle after every response.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r     <= IDLE;
         mem_write_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (count_r != CNT_W'(0)) begin
                  state_r     <= WRITE;
                  mem_write_r <= 1'b1;
               end else begin
                  state_r     <= IDLE;
                  mem_write_r <= 1'b0;
               end
            end
            WRITE: begin
               if (mem_resp) begin
                  state_r     <= IDLE;
                  mem_write_r <= 1'b0;
               end else begin
                  state_r     <= WRITE;
                  mem_write_r <= 1'b1;
               end
            end
            default: begin
               state_r     <= IDLE;
               mem_write_r <= 1'b0;
            end
         endcase
      end
   end

   // Fault pulse follows the cycle in which a bad store was consumed.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         store_fault_r <= 1'b0;
      end else begin
         store_fault_r <= accept_s && align_fault_s;
      end
   end

   // Present the head entry to memory, or zeros when nothing is queued.
   always_comb begin
      mem_address     = 32'h0000_0000;
      mem_wdata       = 32'h0000_0000;
      mem_byte_enable = 4'b0000;
      if (count_r != CNT_W'(0)) begin
         mem_address     = entries_r[head_r].addr;
         mem_wdata       = entries_r[head_r].data;
         mem_byte_enable = entries_r[head_r].mask;
      end else begin
         mem_address     = 32'h0000_0000;
         mem_wdata       = 32'h0000_0000;
         mem_byte_enable = 4'b0000;
      end
   end

   // Word-address match against every queued entry, including the one being written.
   always_comb begin
      hit_s = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         hit_s = hit_s | (valid_r[i] && (entries_r[i].addr[31:2] == ld_addr[31:2]));
      end
      ld_hazard = ld_valid && hit_s;
   end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: a queue-based model checked every cycle, plus
// directed sequences with hand-computed literal expectations.
module tb_store_buffer;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        st_valid;
   logic [2:0]  st_funct3;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        st_ready;
   logic        store_fault;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic        ld_hazard;
   logic        mem_write;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_byte_enable;
   logic        mem_resp;
   logic        empty;

   always #5 clk = ~clk;

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .st_valid        (st_valid),
      .st_funct3       (st_funct3),
      .st_addr         (st_addr),
      .st_data         (st_data),
      .st_ready        (st_ready),
      .store_fault     (store_fault),
      .ld_valid        (ld_valid),
      .ld_addr         (ld_addr),
      .ld_hazard       (ld_hazard),
      .mem_write       (mem_write),
      .mem_address     (mem_address),
      .mem_wdata       (mem_wdata),
      .mem_byte_enable (mem_byte_enable),
      .mem_resp        (mem_resp),
      .empty           (empty)
   );

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  m;
   } ent_t;

   ent_t mq[$];
   bit   m_writing = 1'b0;
   bit   m_fault   = 1'b0;
   bit   live      = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit spec_fault(input logic [2:0] f, input logic [31:0] a);
      if (f == 3'b000) return 1'b0;
      if (f == 3'b001) return a[0];
      if (f == 3'b010) return (a[1:0] != 2'b00);
      return 1'b1;
   endfunction

   function automatic ent_t spec_entry(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
      ent_t e;
      e.a = {a[31:2], 2'b00};
      if (f == 3'b000) begin
         e.d = {4{d[7:0]}};
         e.m = 4'b0001 << a[1:0];
      end else if (f == 3'b001) begin
         e.d = {2{d[15:0]}};
         e.m = a[1] ? 4'b1100 : 4'b0011;
      end else begin
         e.d = d;
         e.m = 4'b1111;
      end
      return e;
   endfunction

   // Model: queue of pending stores plus a "write in flight" flag.
   bit m_acc, m_flt, m_nw;
   initial begin
      forever begin
         @(posedge clk);
         if (!reset_n) begin
            mq.delete();
            m_writing = 1'b0;
            m_fault   = 1'b0;
            live      = 1'b1;
         end else begin
            m_acc = st_valid && (mq.size() < DEPTH);
            m_flt = spec_fault(st_funct3, st_addr);
            m_nw  = m_writing ? !mem_resp : (mq.size() != 0);
            if (m_writing && mem_resp) mq.delete(0);
            if (m_acc && !m_flt) mq.push_back(spec_entry(st_funct3, st_addr, st_data));
            m_writing = m_nw;
            m_fault   = m_acc && m_flt;
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   logic cmp_hz;
   ent_t cmp_hd;
   initial begin
      forever begin
         @(negedge clk);
         if (live) begin
            cmp_hz = 1'b0;
            foreach (mq[i]) if (mq[i].a[31:2] == ld_addr[31:2]) cmp_hz = 1'b1;
            cmp_hz = cmp_hz && ld_valid;
            if (mq.size() != 0) cmp_hd = mq[0];
            else cmp_hd = '{a: 32'h0, d: 32'h0, m: 4'h0};
            chk("m_mem_write", {31'b0, mem_write}, {31'b0, m_writing});
            chk("m_mem_address", mem_address, cmp_hd.a);
            chk("m_mem_wdata", mem_wdata, cmp_hd.d);
            chk("m_byte_enable", {28'b0, mem_byte_enable}, {28'b0, cmp_hd.m});
            chk("m_empty", {31'b0, empty}, {31'b0, mq.size() == 0});
            chk("m_st_ready", {31'b0, st_ready}, {31'b0, mq.size() < DEPTH});
            chk("m_store_fault", {31'b0, store_fault}, {31'b0, m_fault});
            chk("m_ld_hazard", {31'b0, ld_hazard}, {31'b0, cmp_hz});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
      bit rdy;
      bit done;
      done      = 1'b0;
      st_funct3 = f;
      st_addr   = a;
      st_data   = d;
      st_valid  = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         rdy = st_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         n_vec++;
         n_bad++;
         $display("FAIL push_timeout: got st_ready=0, expected acceptance of addr 0x%0h", a);
      end
   endtask

   task automatic wait_write(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (mem_write === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_vec++;
         n_bad++;
         $display("FAIL write_timeout: got mem_write=0, expected 1 within %0d cycles", budget);
      end
   endtask

   task automatic drain(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      bit ok;
      wait_write(40, ok);
      if (ok) begin
         chk({tag, "_addr"}, mem_address, a);
         chk({tag, "_wdata"}, mem_wdata, d);
         chk({tag, "_be"}, {28'b0, mem_byte_enable}, {28'b0, m});
         @(negedge clk);
         chk({tag, "_hold"}, mem_address, a);
         mem_resp = 1'b1;
         @(posedge clk);
         #1;
         mem_resp = 1'b0;
         @(negedge clk);
         chk({tag, "_gap"}, {31'b0, mem_write}, 32'd0);
      end
   endtask

   logic [2:0]  t3_f [5] = '{3'b010, 3'b000, 3'b001, 3'b000, 3'b010};
   logic [31:0] t3_a [5] = '{32'h0000_5000, 32'h0000_5005, 32'h0000_5008, 32'h0000_500E, 32'h0000_5010};
   logic [31:0] t3_d [5] = '{32'h1111_1111, 32'h0000_00C3, 32'hFFFF_5A6B, 32'h1234_5677, 32'hCAFE_F00D};
   logic [31:0] t3_ea[5] = '{32'h0000_5000, 32'h0000_5004, 32'h0000_5008, 32'h0000_500C, 32'h0000_5010};
   logic [31:0] t3_ed[5] = '{32'h1111_1111, 32'hC3C3_C3C3, 32'h5A6B_5A6B, 32'h7777_7777, 32'hCAFE_F00D};
   logic [3:0]  t3_em[5] = '{4'b1111, 4'b0010, 4'b0011, 4'b0100, 4'b1111};

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish before 200000");
      $fatal(1);
   end

   initial begin
      bit ok;
      reset_n   = 1'b0;
      st_valid  = 1'b0;
      st_funct3 = 3'b000;
      st_addr   = 32'h0;
      st_data   = 32'h0;
      ld_valid  = 1'b0;
      ld_addr   = 32'h0;
      mem_resp  = 1'b0;
      tick();
      tick();
      @(negedge clk);
      chk("rst_empty", {31'b0, empty}, 32'd1);
      chk("rst_ready", {31'b0, st_ready}, 32'd1);
      chk("rst_mw", {31'b0, mem_write}, 32'd0);
      chk("rst_addr", mem_address, 32'h0);
      reset_n = 1'b1;
      tick();

      // sb to byte 3, single drain
      push_store(3'b000, 32'h0000_1003, 32'h0000_00AB);
      st_valid = 1'b0;
      @(negedge clk);
      chk("t1_empty_n1", {31'b0, empty}, 32'd0);
      chk("t1_mw_n1", {31'b0, mem_write}, 32'd0);
      @(negedge clk);
      chk("t1_mw_n2", {31'b0, mem_write}, 32'd1);
      chk("t1_addr", mem_address, 32'h0000_1000);
      chk("t1_wdata", mem_wdata, 32'hABAB_ABAB);
      chk("t1_be", {28'b0, mem_byte_enable}, 32'h8);
      @(negedge clk);
      chk("t1_hold", mem_wdata, 32'hABAB_ABAB);
      mem_resp = 1'b1;
      @(posedge clk);
      #1;
      mem_resp = 1'b0;
      @(negedge clk);
      chk("t1_mw_after", {31'b0, mem_write}, 32'd0);
      chk("t1_empty_after", {31'b0, empty}, 32'd1);
      tick();

      // sh then sw, in order with one idle cycle between
      push_store(3'b001, 32'h0000_2002, 32'h0000_1234);
      push_store(3'b010, 32'h0000_3000, 32'hDEAD_BEEF);
      st_valid = 1'b0;
      drain("t2a", 32'h0000_2000, 32'h1234_1234, 4'b1100);
      @(negedge clk);
      chk("t2_rewrite", {31'b0, mem_write}, 32'd1);
      drain("t2b", 32'h0000_3000, 32'hDEAD_BEEF, 4'b1111);
      tick();

      // full buffer, back-pressure and pointer wrap
      fork
         begin
            for (int i = 0; i < 5; i++) push_store(t3_f[i], t3_a[i], t3_d[i]);
            st_valid = 1'b0;
         end
         begin
            repeat (3) @(negedge clk);
            chk("t3_ready_full", {31'b0, st_ready}, 32'd0);
            chk("t3_mw_full", {31'b0, mem_write}, 32'd1);
            for (int i = 0; i < 5; i++) drain($sformatf("t3_%0d", i), t3_ea[i], t3_ed[i], t3_em[i]);
         end
      join
      tick();

      // faulting stores: misaligned sw, reserved funct3, misaligned sh
      st_funct3 = 3'b010; st_addr = 32'h0000_4001; st_data = 32'h1; st_valid = 1'b1;
      tick();
      st_valid = 1'b0;
      @(negedge clk);
      chk("t4_sw_fault", {31'b0, store_fault}, 32'd1);
      chk("t4_sw_empty", {31'b0, empty}, 32'd1);
      tick();
      @(negedge clk);
      chk("t4_sw_pulse", {31'b0, store_fault}, 32'd0);
      chk("t4_sw_mw", {31'b0, mem_write}, 32'd0);
      st_funct3 = 3'b011; st_addr = 32'h0000_4000; st_valid = 1'b1;
      tick();
      st_valid = 1'b0;
      @(negedge clk);
      chk("t4_rsv_fault", {31'b0, store_fault}, 32'd1);
      tick();
      @(negedge clk);
      chk("t4_rsv_pulse", {31'b0, store_fault}, 32'd0);
      chk("t4_rsv_empty", {31'b0, empty}, 32'd1);
      st_funct3 = 3'b001; st_addr = 32'h0000_4003; st_valid = 1'b1;
      tick();
      st_valid = 1'b0;
      tick();
      tick();

      // load hazard against a pending store
      push_store(3'b010, 32'h0000_1000, 32'h55AA_55AA);
      st_valid = 1'b0;
      ld_valid = 1'b1;
      ld_addr  = 32'h0000_1002;
      @(negedge clk);
      chk("t5_hit", {31'b0, ld_hazard}, 32'd1);
      tick();
      ld_addr = 32'h0000_1004;
      @(negedge clk);
      chk("t5_miss", {31'b0, ld_hazard}, 32'd0);
      tick();
      ld_addr = 32'h0000_1002;
      drain("t5", 32'h0000_1000, 32'h55AA_55AA, 4'b1111);
      chk("t5_after", {31'b0, ld_hazard}, 32'd0);
      tick();
      ld_valid = 1'b0;

      // reset while writing with two entries queued
      push_store(3'b010, 32'h0000_6000, 32'h0000_0001);
      push_store(3'b010, 32'h0000_6004, 32'h0000_0002);
      st_valid = 1'b0;
      wait_write(10, ok);
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      tick();
      reset_n  = 1'b1;
      mem_resp = 1'b1;
      @(negedge clk);
      chk("t6_mw", {31'b0, mem_write}, 32'd0);
      chk("t6_empty", {31'b0, empty}, 32'd1);
      chk("t6_ready", {31'b0, st_ready}, 32'd1);
      tick();
      mem_resp = 1'b0;
      @(negedge clk);
      chk("t6_late_mw", {31'b0, mem_write}, 32'd0);
      chk("t6_late_empty", {31'b0, empty}, 32'd1);
      tick();
      @(negedge clk);
      chk("t6_idle_mw", {31'b0, mem_write}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
